// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM requester arbiter.
// Requester addresses are always 9 bits wide. The RAM uses only the low AW bits.
package dpram_arb_pkg;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 16;
  localparam int REQ_AW  = 9;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;

  // Names the port that wins the next same-address conflict.
  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_t;

endpackage

// File: rtl/dpram_port_arbiter.sv
// Round-robin req/gnt arbiter that sits in front of a true dual-port synchronous RAM.
// Same-address accesses that include a write are serialized, and the losing port is stalled.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [8:0]    p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [8:0]    p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,

  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic          ram_we_a,
  input  logic [DW-1:0] ram_q_a,

  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_b,

  output logic [CW-1:0] conflict_cnt
);

  prio_t prio;
  logic  rd_pend_0, rd_pend_1;
  logic  conflict;

  // The upper address bits are outside the RAM's range and are intentionally ignored.
  logic  unused_addr_hi;
  assign unused_addr_hi = ^{p0_addr[8:AW], p1_addr[8:AW]};

  assign conflict = p0_req && p1_req
                 && (p0_addr[AW-1:0] == p1_addr[AW-1:0])
                 && (p0_we || p1_we);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (conflict) begin
        p0_gnt = (prio == PRIO_P0);
        p1_gnt = (prio == PRIO_P1);
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign ram_addr_a = p0_addr[AW-1:0];
  assign ram_addr_b = p1_addr[AW-1:0];
  assign ram_data_a = p0_wdata;
  assign ram_data_b = p1_wdata;
  assign ram_we_a   = p0_gnt & p0_we;
  assign ram_we_b   = p1_gnt & p1_we;

  assign p0_rvalid  = rd_pend_0;
  assign p1_rvalid  = rd_pend_1;
  assign p0_rdata   = ram_q_a;
  assign p1_rdata   = ram_q_b;

  // NOTE: sequential state uses non-blocking assignments, so all flops sample the pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio         <= PRIO_P0;
      rd_pend_0    <= 1'b0;
      rd_pend_1    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      rd_pend_0 <= p0_gnt & ~p0_we;
      rd_pend_1 <= p1_gnt & ~p1_we;
      if (conflict) begin
        // The loser of this conflict takes priority for the next one.
        prio <= (prio == PRIO_P0) ? PRIO_P1 : PRIO_P0;
        if (conflict_cnt != '1) begin
          conflict_cnt <= conflict_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

- Sits between the two CPU data-memory ports (p0, p1) and the shared true dual-port synchronous RAM; p0 drives RAM port A, p1 drives RAM port B.
- Replaces fixed "p1 write wins, p0 write silently dropped" conflict resolution with a req/gnt handshake.
- Same-address accesses involving a write are serialized under round-robin priority; the loser is stalled, never dropped.
- Also tracks read-data validity and counts conflicts for debug.

## Interface

Parameters:
- AW, 8, RAM address width; requester addresses are 9 bits, upper bits ignored.
- DW, 16, data width.
- CW, 16, conflict counter width.

Ports (x = 0, 1):
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- px_req  in  1  requester x access request; held with addr/we/wdata stable until px_gnt.
- px_we  in  1  1 = write, 0 = read.
- px_addr  in  9  word address; only [AW-1:0] used.
- px_wdata  in  DW  write data.
- px_gnt  out  1  access accepted this cycle (combinational).
- px_rvalid  out  1  px_rdata valid: granted read from the previous cycle.
- px_rdata  out  DW  read data, passed through from RAM q.
- ram_addr_a / ram_addr_b  out  AW  RAM address for port A / B.
- ram_data_a / ram_data_b  out  DW  RAM write data.
- ram_we_a / ram_we_b  out  1  RAM write enable.
- ram_q_a / ram_q_b  in  DW  RAM registered read data, one cycle after address.
- conflict_cnt  out  CW  saturating count of cycles with a resolved conflict.

## Operation

- Conflict condition, all of:
  - p0_req and p1_req both high;
  - p0_addr[AW-1:0] == p1_addr[AW-1:0];
  - (p0_we | p1_we).
- Same-address read/read is not a conflict: both are granted.
- No conflict: px_gnt = px_req for both ports.
- Conflict: only the priority holder is granted; the other sees px_gnt = 0 and must hold its request.
- Priority flop prio: 0 means p0 wins, 1 means p1 wins.
  - After each resolved conflict, prio is set to the loser, so it wins the next conflict cycle.
  - Consequence: a stalled requester waits at most one cycle.
- prio does not change in non-conflict cycles.
- RAM drive:
  - ram_addr_* and ram_data_* follow their requester unconditionally.
  - ram_we_x = px_gnt & px_we.
- Read tracking:
  - rd_pend_x <= px_gnt & ~px_we.
  - px_rvalid = rd_pend_x; px_rdata = ram_q_x.
- Write-then-read of the same address by one port on back-to-back cycles returns the new data; this relies on RAM ordering and is not handled by the arbiter.
- conflict_cnt increments on each conflict cycle and saturates at all-ones.
- Reset asserted:
  - prio = 0, rd_pend_* = 0, conflict_cnt = 0;
  - px_gnt and ram_we_* are forced to 0 combinationally while rst is high.
- Reset mid-operation: any in-flight read is discarded (rvalid low); requesters must re-request after rst deasserts.

## Timing

- Grant: same cycle as request, combinational from req/addr/we/prio; no registered path.
- Write: committed at the clk edge ending the grant cycle.
- Read: granted in cycle N; px_rvalid = 1 with data in cycle N+1. Back-to-back reads sustain one per cycle per port.
- Stall: the conflict loser is granted in the next cycle if it still requests, with no bubble for the winner.
- prio, rd_pend, conflict_cnt: updated on the rising clk edge, async-cleared by rst.
- Outputs after reset: gnt 0, rvalid 0, we 0, conflict_cnt 0.
- Addresses pass through, so they are defined from the first cycle.

## Structure

- Shared package dpram_arb_pkg:
  - AW_DEF / DW_DEF constants;
  - typedef mem_req_t {req, we, addr[8:0], wdata};
  - enum prio_t {PRIO_P0, PRIO_P1}.
- Single module; no sub-module required.
- The saturating counter is inline logic, not a separate instance.
- Top level instantiates the arbiter between the cpu and true_dpram_sclk, deleting the old ad hoc we masking.

## Test plan

- Independent traffic: p0 writes 0x1234 @0x10, p1 writes 0xBEEF @0x20 in the same cycle.
  - Both gnt = 1; p0 then reads 0x10 and p1 reads 0x20.
  - Next cycle rdata = 0x1234 / 0xBEEF with rvalid = 1.
- Write/write conflict from reset: both write @0x05 (p0 0xAAAA, p1 0x5555).
  - Cycle 0: p0_gnt = 1, p1_gnt = 0.
  - Cycle 1: p1_gnt = 1.
  - Final read @0x05 = 0x5555; conflict_cnt = 1.
- Alternation: both requesters continuously write @0x07 for 6 cycles.
  - Grants alternate p0, p1, p0, p1, p0, p1; conflict_cnt = 6.
  - Neither port stalls for more than 1 cycle.
- Read/read same address @0x30 (holds 0x0042): both gnt = 1 in the same cycle; both rdata = 0x0042 next cycle; conflict_cnt unchanged.
- Read/write conflict with prio = 1: p0 reads and p1 writes 0x9999 @0x40.
  - p1 granted first; p0 granted the next cycle.
  - p0_rdata = 0x9999 one cycle later.
- Reset mid-read: assert rst asynchronously in the cycle after a granted read.
  - rvalid drops immediately; gnt = 0 while rst is high.
  - After release: prio = 0 and conflict_cnt = 0.
